// File: rtl/md_init_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : md_init_dump_ctrl
// Brief    : Walks cell IDs for host init streams and per-cell dump sequences.
// Revision : 1.0
// ============================================================================
module md_init_dump_ctrl #(
    parameter int NUM_CELLS_MAX  = 27,
    parameter int TDEST_WIDTH    = 16,
    parameter int MAX_DUMP_BEATS = 256,
    parameter int BEAT_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic                      i_cmd_op,
    input  logic [TDEST_WIDTH-1:0]    i_cmd_num_cells,
    input  logic                      i_s_axis_h2k_tvalid,
    input  logic                      i_s_axis_h2k_tlast,
    input  logic [TDEST_WIDTH-1:0]    i_s_axis_h2k_tdest,
    output logic                      o_s_axis_h2k_tready,
    input  logic                      i_dump_tvalid,
    input  logic                      i_dump_end,
    output logic                      o_init_start,
    output logic                      o_dump_start,
    output logic [TDEST_WIDTH-1:0]    o_init_ID,
    output logic [BEAT_CNT_WIDTH-1:0] o_beat_count,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT_CELL = 3'd1,
        S_INIT_NEXT = 3'd2,
        S_DUMP_CELL = 3'd3,
        S_DUMP_NEXT = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam logic [TDEST_WIDTH-1:0]    c_NUM_MAX  = TDEST_WIDTH'(NUM_CELLS_MAX);
    localparam logic [BEAT_CNT_WIDTH-1:0] c_BEAT_SAT = '1;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [TDEST_WIDTH-1:0]      r_cell;
    logic [TDEST_WIDTH-1:0]      w_cell_nxt;
    logic [TDEST_WIDTH-1:0]      r_num;
    logic [TDEST_WIDTH-1:0]      w_num_nxt;
    logic [TDEST_WIDTH-1:0]      w_num_clamped;
    logic [BEAT_CNT_WIDTH-1:0]   r_beat;
    logic [BEAT_CNT_WIDTH-1:0]   w_beat_nxt;
    logic [BEAT_CNT_WIDTH-1:0]   w_beat_inc;
    logic                        r_err;
    logic                        w_err_nxt;
    logic                        w_last_cell;
    logic                        w_dump_limit;

    assign w_num_clamped = (i_cmd_num_cells > c_NUM_MAX) ? c_NUM_MAX : i_cmd_num_cells;
    assign w_beat_inc    = (r_beat == c_BEAT_SAT) ? r_beat : r_beat + BEAT_CNT_WIDTH'(1);
    assign w_last_cell   = (r_cell == r_num - TDEST_WIDTH'(1));
    // Timeout is judged on the count including the beat arriving now.
    assign w_dump_limit  = (int'(w_beat_inc) >= MAX_DUMP_BEATS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cell  <= '0;
            r_num   <= '0;
            r_beat  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cell  <= w_cell_nxt;
            r_num   <= w_num_nxt;
            r_beat  <= w_beat_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cell_nxt  = r_cell;
        w_num_nxt   = r_num;
        w_beat_nxt  = r_beat;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    w_num_nxt  = w_num_clamped;
                    w_cell_nxt = '0;
                    w_beat_nxt = '0;
                    if (w_num_clamped == '0) begin
                        w_state_nxt = S_DONE;
                    end else if (i_cmd_op) begin
                        w_state_nxt = S_DUMP_CELL;
                    end else begin
                        w_state_nxt = S_INIT_CELL;
                    end
                end
            end
            S_INIT_CELL: begin
                if (i_s_axis_h2k_tvalid) begin
                    if (i_s_axis_h2k_tdest == r_cell) begin
                        w_beat_nxt = w_beat_inc;
                        if (i_s_axis_h2k_tlast) begin
                            w_state_nxt = S_INIT_NEXT;
                        end
                    end else begin
                        // Misrouted beat is still consumed; only flagged.
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_DUMP_CELL: begin
                if (i_dump_tvalid) begin
                    w_beat_nxt = w_beat_inc;
                    if (i_dump_end) begin
                        w_state_nxt = S_DUMP_NEXT;
                    end else if (w_dump_limit) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_DUMP_NEXT;
                    end
                end
            end
            S_INIT_NEXT, S_DUMP_NEXT: begin
                if (w_last_cell) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cell_nxt  = r_cell + TDEST_WIDTH'(1);
                    w_beat_nxt  = '0;
                    w_state_nxt = (r_state == S_INIT_NEXT) ? S_INIT_CELL : S_DUMP_CELL;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_cmd_ready         = (r_state == S_IDLE);
    assign o_busy              = (r_state != S_IDLE);
    assign o_done              = (r_state == S_DONE);
    assign o_init_start        = (r_state == S_INIT_CELL);
    assign o_dump_start        = (r_state == S_DUMP_CELL);
    assign o_s_axis_h2k_tready = (r_state == S_INIT_CELL);
    assign o_init_ID           = r_cell;
    assign o_beat_count        = r_beat;
    assign o_err               = r_err;

endmodule
`default_nettype wire

// File: tb/tb_md_init_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_init_dump_ctrl
// Brief    : Randomized scenario bench for md_init_dump_ctrl with a cell-walk model.
// Revision : 1.0
// ============================================================================
module tb_md_init_dump_ctrl;

    localparam int TW   = 16;
    localparam int BW   = 16;
    localparam int NMAX = 27;
    localparam int MAXB = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_cmd_valid = 1'b0;
    logic          o_cmd_ready;
    logic          i_cmd_op = 1'b0;
    logic [TW-1:0] i_cmd_num_cells = '0;
    logic          i_s_axis_h2k_tvalid = 1'b0;
    logic          i_s_axis_h2k_tlast = 1'b0;
    logic [TW-1:0] i_s_axis_h2k_tdest = '0;
    logic          o_s_axis_h2k_tready;
    logic          i_dump_tvalid = 1'b0;
    logic          i_dump_end = 1'b0;
    logic          o_init_start;
    logic          o_dump_start;
    logic [TW-1:0] o_init_ID;
    logic [BW-1:0] o_beat_count;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    int n_checks = 0;
    int n_errors = 0;

    md_init_dump_ctrl #(
        .NUM_CELLS_MAX  (NMAX),
        .TDEST_WIDTH    (TW),
        .MAX_DUMP_BEATS (MAXB),
        .BEAT_CNT_WIDTH (BW)
    ) u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_cmd_valid         (i_cmd_valid),
        .o_cmd_ready         (o_cmd_ready),
        .i_cmd_op            (i_cmd_op),
        .i_cmd_num_cells     (i_cmd_num_cells),
        .i_s_axis_h2k_tvalid (i_s_axis_h2k_tvalid),
        .i_s_axis_h2k_tlast  (i_s_axis_h2k_tlast),
        .i_s_axis_h2k_tdest  (i_s_axis_h2k_tdest),
        .o_s_axis_h2k_tready (o_s_axis_h2k_tready),
        .i_dump_tvalid       (i_dump_tvalid),
        .i_dump_end          (i_dump_end),
        .o_init_start        (o_init_start),
        .o_dump_start        (o_dump_start),
        .o_init_ID           (o_init_ID),
        .o_beat_count        (o_beat_count),
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_err               (o_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compares every output against the expected view of the controller.
    task automatic expect_o(input string tag, input bit ini, input bit dmp, input int id,
                            input int beat, input bit busy, input bit done, input bit err);
        chk({tag, "/init_start"}, 32'(o_init_start), 32'(ini));
        chk({tag, "/dump_start"}, 32'(o_dump_start), 32'(dmp));
        chk({tag, "/tready"},     32'(o_s_axis_h2k_tready), 32'(ini));
        chk({tag, "/init_ID"},    32'(o_init_ID), 32'(id));
        chk({tag, "/beat_count"}, 32'(o_beat_count), 32'(beat));
        chk({tag, "/busy"},       32'(o_busy), 32'(busy));
        chk({tag, "/cmd_ready"},  32'(o_cmd_ready), 32'(!busy));
        chk({tag, "/done"},       32'(o_done), 32'(done));
        chk({tag, "/err"},        32'(o_err), 32'(err));
    endtask

    // Randomizes every input; callers then override the ones that matter.
    task automatic noise();
        i_cmd_valid         = 1'($urandom_range(0, 1));
        i_cmd_op            = 1'($urandom_range(0, 1));
        i_cmd_num_cells     = TW'($urandom_range(0, 60));
        i_s_axis_h2k_tvalid = 1'($urandom_range(0, 1));
        i_s_axis_h2k_tlast  = 1'($urandom_range(0, 1));
        i_s_axis_h2k_tdest  = TW'($urandom_range(0, 40));
        i_dump_tvalid       = 1'($urandom_range(0, 1));
        i_dump_end          = 1'($urandom_range(0, 1));
    endtask

    task automatic quiet();
        i_cmd_valid         = 1'b0;
        i_s_axis_h2k_tvalid = 1'b0;
        i_s_axis_h2k_tlast  = 1'b0;
        i_dump_tvalid       = 1'b0;
        i_dump_end          = 1'b0;
    endtask

    function automatic int clamp(input int n);
        return (n > NMAX) ? NMAX : n;
    endfunction

    task automatic issue(input int num, input bit op);
        quiet();
        i_cmd_valid     = 1'b1;
        i_cmd_op        = op;
        i_cmd_num_cells = TW'(num);
        step();
    endtask

    task automatic finish_run(input string tag, input int last_id, input int beat);
        expect_o({tag, "_done"}, 0, 0, last_id, beat, 1, 1, 0);
        noise();
        step();
        expect_o({tag, "_idle"}, 0, 0, last_id, beat, 0, 0, 0);
        quiet();
    endtask

    // Init command; abort_cell >= 0 resets the DUT after the first beat of that cell.
    task automatic run_init(input int num, input int abort_cell);
        int nc;
        int nb;
        int cnt;
        nc = clamp(num);
        issue(num, 1'b0);
        cnt = 0;
        if (nc == 0) begin
            finish_run("init0", 0, 0);
            return;
        end
        for (int c = 0; c < nc; c++) begin
            expect_o("init_enter", 1, 0, c, 0, 1, 0, 0);
            nb  = $urandom_range(1, 3);
            cnt = 0;
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 2) == 0) begin
                    noise();
                    i_s_axis_h2k_tvalid = 1'b0;
                    step();
                    expect_o("init_bubble", 1, 0, c, cnt, 1, 0, 0);
                end
                if ($urandom_range(0, 3) == 0) begin
                    noise();
                    i_s_axis_h2k_tvalid = 1'b1;
                    i_s_axis_h2k_tdest  = TW'(c + 1 + $urandom_range(0, 5));
                    step();
                    expect_o("init_misroute", 1, 0, c, cnt, 1, 0, 1);
                end
                noise();
                i_s_axis_h2k_tvalid = 1'b1;
                i_s_axis_h2k_tdest  = TW'(c);
                i_s_axis_h2k_tlast  = (b == nb - 1);
                step();
                cnt++;
                if (c == abort_cell) begin
                    quiet();
                    rst_n = 1'b0;
                    step();
                    expect_o("abort_rst", 0, 0, 0, 0, 0, 0, 0);
                    rst_n = 1'b1;
                    for (int k = 0; k < 3; k++) begin
                        step();
                        expect_o("abort_idle", 0, 0, 0, 0, 0, 0, 0);
                    end
                    return;
                end
                if (b < nb - 1) begin
                    expect_o("init_beat", 1, 0, c, cnt, 1, 0, 0);
                end
            end
            expect_o("init_gap", 0, 0, c, cnt, 1, 0, 0);
            noise();
            step();
        end
        finish_run("init", nc - 1, cnt);
    endtask

    task automatic run_dump(input int num);
        int nc;
        int len;
        int cnt;
        bit ended;
        nc = clamp(num);
        issue(num, 1'b1);
        cnt = 0;
        if (nc == 0) begin
            finish_run("dump0", 0, 0);
            return;
        end
        for (int c = 0; c < nc; c++) begin
            expect_o("dump_enter", 0, 1, c, 0, 1, 0, 0);
            len   = $urandom_range(1, 10);
            cnt   = 0;
            ended = 1'b0;
            while (!ended) begin
                if ($urandom_range(0, 2) == 0) begin
                    noise();
                    i_dump_tvalid = 1'b0;
                    step();
                    expect_o("dump_bubble", 0, 1, c, cnt, 1, 0, 0);
                end
                noise();
                i_dump_tvalid = 1'b1;
                i_dump_end    = (cnt + 1 == len);
                step();
                cnt++;
                if (cnt == len) begin
                    ended = 1'b1;
                    expect_o("dump_end", 0, 0, c, cnt, 1, 0, 0);
                end else if (cnt == MAXB) begin
                    ended = 1'b1;
                    expect_o("dump_timeout", 0, 0, c, cnt, 1, 0, 1);
                end else begin
                    expect_o("dump_beat", 0, 1, c, cnt, 1, 0, 0);
                end
            end
            noise();
            step();
        end
        finish_run("dump", nc - 1, cnt);
    endtask

    initial begin
        quiet();
        rst_n = 1'b0;
        step();
        step();
        expect_o("reset", 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step();
        expect_o("post_reset", 0, 0, 0, 0, 0, 0, 0);

        run_init(3, -1);
        run_init(2, -1);
        run_dump(2);
        run_dump(3);
        run_init(0, -1);
        run_dump(0);
        run_init(40, -1);
        run_dump(40);
        run_init(3, 1);
        run_dump(1);
        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                run_dump($urandom_range(0, 6));
            end else begin
                run_init($urandom_range(0, 6), -1);
            end
            step();
            expect_o("between", 0, 0, o_init_ID, o_beat_count, 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
